// File: rtl/board_input_pkg.sv
// Shared constants, FSM encoding and index helpers for the board_input button front end.
package board_input_pkg;

    localparam int unsigned NUM_BUTTONS = 9;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned CNT_W       = 20;

    // Cell index = 3*x + y for cell xy.
    localparam int unsigned CELL_00 = 0;
    localparam int unsigned CELL_01 = 1;
    localparam int unsigned CELL_02 = 2;
    localparam int unsigned CELL_10 = 3;
    localparam int unsigned CELL_11 = 4;
    localparam int unsigned CELL_12 = 5;
    localparam int unsigned CELL_20 = 6;
    localparam int unsigned CELL_21 = 7;
    localparam int unsigned CELL_22 = 8;

    typedef enum logic [1:0] {
        StIdle        = 2'b00,
        StPending     = 2'b01,
        StEmit        = 2'b10,
        StWaitRelease = 2'b11
    } state_e;

    // Lowest set bit wins; an all-zero vector maps to index 0.
    function automatic logic [SEL_W-1:0] lowest_index(input logic [NUM_BUTTONS-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

    // Out-of-range selects decode to all-zero rather than aliasing a cell.
    function automatic logic [NUM_BUTTONS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_BUTTONS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (sel == SEL_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/board_input_debounce_ch.sv
// One button channel: 2-flop synchronizer, stable-count debouncer and rising-edge press event.
module debounce_ch
    import board_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             w_differs;
    logic             w_accept;

    assign w_differs = (r_sync2 != r_level);
    assign w_accept  = w_differs && (r_cnt == CntLast);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The count tracks how many consecutive synced samples disagreed with the level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= w_accept && !r_level;
            if (!w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
            if (w_accept) begin
                r_level <= ~r_level;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/board_input.sv
// Nine-button board input: debounce, pick one press, emit a single cell pulse.
// Optional macro BOARD_INPUT_BLANK_SYNC_EN holds the pulse until vertical blanking.
module board_input
    import board_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    input  logic                   vnotactive,
    output logic                   board_but00,
    output logic                   board_but01,
    output logic                   board_but02,
    output logic                   board_but10,
    output logic                   board_but11,
    output logic                   board_but12,
    output logic                   board_but20,
    output logic                   board_but21,
    output logic                   board_but22,
    output logic                   busy
);

    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_press;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_raw   (btn_raw[g]),
            .o_level (w_level[g]),
            .o_press (w_press[g])
        );
    end

    state_e                 r_state;
    state_e                 w_state_d;
    logic [SEL_W-1:0]       r_sel;
    logic [SEL_W-1:0]       w_sel_d;
    logic [NUM_BUTTONS-1:0] r_but;
    logic [NUM_BUTTONS-1:0] w_but_d;
    logic                   r_busy;
    logic                   w_busy_d;
    logic                   w_blank_ok;

`ifdef BOARD_INPUT_BLANK_SYNC_EN
    assign w_blank_ok = vnotactive;
`else
    logic w_unused_vnot;
    assign w_unused_vnot = vnotactive;
    assign w_blank_ok    = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_d;
            r_sel   <= w_sel_d;
        end
    end

    // Presses outside StIdle are simply ignored; nothing is queued.
    always_comb begin
        w_state_d = r_state;
        w_sel_d   = r_sel;
        unique case (r_state)
            StIdle: begin
                if (|w_press) begin
                    w_sel_d   = lowest_index(w_press);
                    w_state_d = StPending;
                end
            end
            StPending: begin
                if (w_blank_ok) begin
                    w_state_d = StEmit;
                end
            end
            StEmit: begin
                w_state_d = StWaitRelease;
            end
            StWaitRelease: begin
                if (!(|w_level)) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        w_but_d  = '0;
        w_busy_d = (w_state_d != StIdle);
        if (r_state == StEmit) begin
            w_but_d = sel_onehot(r_sel);
        end
    end

    // Pulse lands the cycle after StEmit, so a reset during StEmit cancels it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_but  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_but  <= w_but_d;
            r_busy <= w_busy_d;
        end
    end

    assign board_but00 = r_but[CELL_00];
    assign board_but01 = r_but[CELL_01];
    assign board_but02 = r_but[CELL_02];
    assign board_but10 = r_but[CELL_10];
    assign board_but11 = r_but[CELL_11];
    assign board_but12 = r_but[CELL_12];
    assign board_but20 = r_but[CELL_20];
    assign board_but21 = r_but[CELL_21];
    assign board_but22 = r_but[CELL_22];
    assign busy        = r_busy;

endmodule
